// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - execute stage: operand forwarding, ALU, branch resolution, EX/MEM register
module ex_stage #(
   parameter int XLEN  = 32,
   parameter int OP_W  = 5,
   parameter int CAT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       stall,
   input  logic [XLEN-1:0]  pc_i,
   input  logic [XLEN-1:0]  npc_i,
   input  logic [XLEN-1:0]  rs1_data_i,
   input  logic [XLEN-1:0]  rs2_data_i,
   input  logic             rs1_request_i,
   input  logic             rs2_request_i,
   input  logic [4:0]       rs1_addr_i,
   input  logic [4:0]       rs2_addr_i,
   input  logic [XLEN-1:0]  imm1_i,
   input  logic [XLEN-1:0]  imm2_i,
   input  logic             imm_rs1_sel_i,
   input  logic             imm_rs2_sel_i,
   input  logic [4:0]       rd_addr_i,
   input  logic             rd_write_i,
   input  logic             rd_load_i,
   input  logic [OP_W-1:0]  op_i,
   input  logic [CAT_W-1:0] catagory_i,
   input  logic [XLEN-1:0]  branch_offset_i,
   input  logic             branch_addr_change_i,
   input  logic             predict_result_i,
   input  logic [4:0]       wb_rd_addr_i,
   input  logic             wb_rd_write_i,
   input  logic [XLEN-1:0]  wb_rd_data_i,
   output logic [XLEN-1:0]  alu_result_o,
   output logic [XLEN-1:0]  store_data_o,
   output logic [4:0]       rd_addr_o,
   output logic             rd_write_o,
   output logic             rd_load_o,
   output logic [OP_W-1:0]  op_o,
   output logic [CAT_W-1:0] catagory_o,
   output logic             branch_error_o,
   output logic [XLEN-1:0]  redirect_pc_o,
   output logic             load_use_stall_o
);

   localparam logic [1:0] ST_PASS = 2'b00;
   localparam logic [1:0] ST_BUBB = 2'b10;

   localparam logic [CAT_W-1:0] CAT_ALU = 3'd1, CAT_BR = 3'd2, CAT_JMP = 3'd3,
                                CAT_LD  = 3'd4, CAT_ST = 3'd5;

   logic [XLEN-1:0]  alu_result_q, alu_result_d, store_data_q, store_data_d;
   logic [XLEN-1:0]  redirect_q, redirect_d;
   logic [4:0]       rd_addr_q, rd_addr_d;
   logic             rd_write_q, rd_write_d, rd_load_q, rd_load_d;
   logic [OP_W-1:0]  op_q, op_d;
   logic [CAT_W-1:0] cat_q, cat_d;
   logic             err_q, err_d, err_held_q, err_held_d;

   logic [XLEN-1:0]  rs1_fwd, rs2_fwd, op_a, op_b, alu_res, pc_plus4, jmp_tgt, actual_npc;
   logic             taken, is_ctrl, mispredict, lu_rs1, lu_rs2, flush, ex_valid;
   logic             unused_predict;

   assign unused_predict = predict_result_i;

   // Own EX/MEM result outranks MEM/WB; a load in EX/MEM has no data yet and is never forwarded.
   always_comb begin
      rs1_fwd = rs1_data_i;
      if (rs1_addr_i != 5'd0 && rd_write_q && !rd_load_q && rd_addr_q == rs1_addr_i)
         rs1_fwd = alu_result_q;
      else if (rs1_addr_i != 5'd0 && wb_rd_write_i && wb_rd_addr_i == rs1_addr_i)
         rs1_fwd = wb_rd_data_i;
      rs2_fwd = rs2_data_i;
      if (rs2_addr_i != 5'd0 && rd_write_q && !rd_load_q && rd_addr_q == rs2_addr_i)
         rs2_fwd = alu_result_q;
      else if (rs2_addr_i != 5'd0 && wb_rd_write_i && wb_rd_addr_i == rs2_addr_i)
         rs2_fwd = wb_rd_data_i;
      op_a = imm_rs1_sel_i ? imm1_i : rs1_fwd;
      op_b = imm_rs2_sel_i ? imm2_i : rs2_fwd;
   end

   always_comb begin
      pc_plus4 = pc_i + XLEN'(4);
      alu_res  = '0;
      taken    = 1'b0;
      case (op_i)
         5'd1:  alu_res = op_a + op_b;
         5'd2:  alu_res = op_a - op_b;
         5'd3:  alu_res = op_a << op_b[4:0];
         5'd4:  alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
         5'd5:  alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
         5'd6:  alu_res = op_a ^ op_b;
         5'd7:  alu_res = op_a >> op_b[4:0];
         5'd8:  alu_res = $unsigned($signed(op_a) >>> op_b[4:0]);
         5'd9:  alu_res = op_a | op_b;
         5'd10: alu_res = op_a & op_b;
         5'd11: taken = (op_a == op_b);
         5'd12: taken = (op_a != op_b);
         5'd13: taken = ($signed(op_a) < $signed(op_b));
         5'd14: taken = ($signed(op_a) >= $signed(op_b));
         5'd15: taken = (op_a < op_b);
         5'd16: taken = (op_a >= op_b);
         default: alu_res = '0;
      endcase
      jmp_tgt = (branch_addr_change_i ? op_a : pc_i) + branch_offset_i;
      if (branch_addr_change_i)
         jmp_tgt[0] = 1'b0;
      is_ctrl    = (catagory_i == CAT_BR) || (catagory_i == CAT_JMP);
      actual_npc = pc_plus4;
      if (catagory_i == CAT_JMP)
         actual_npc = jmp_tgt;
      else if (catagory_i == CAT_BR && taken)
         actual_npc = pc_i + branch_offset_i;
      mispredict = is_ctrl && (actual_npc != npc_i);
   end

   always_comb begin
      lu_rs1 = rs1_request_i && !imm_rs1_sel_i && (rs1_addr_i == rd_addr_q);
      lu_rs2 = rs2_request_i && !imm_rs2_sel_i && (rs2_addr_i == rd_addr_q);
      load_use_stall_o = rd_load_q && rd_write_q && (rd_addr_q != 5'd0) && (lu_rs1 || lu_rs2);
   end

   // While branch_error_o is high the instruction in EX is wrong-path and is squashed.
   always_comb begin
      flush    = (stall == ST_BUBB) || load_use_stall_o || err_q;
      ex_valid = !flush;
      err_d    = mispredict && ex_valid && !err_held_q;
      redirect_d = err_d ? actual_npc : '0;
      err_held_d = (stall != ST_PASS && stall != ST_BUBB) ? (err_held_q || err_d) : 1'b0;
      alu_result_d = alu_result_q;
      store_data_d = store_data_q;
      rd_addr_d    = rd_addr_q;
      rd_write_d   = rd_write_q;
      rd_load_d    = rd_load_q;
      op_d         = op_q;
      cat_d        = cat_q;
      if (flush) begin
         alu_result_d = '0;
         store_data_d = '0;
         rd_addr_d    = '0;
         rd_write_d   = 1'b0;
         rd_load_d    = 1'b0;
         op_d         = '0;
         cat_d        = '0;
      end else if (stall == ST_PASS) begin
         case (catagory_i)
            CAT_ALU:        alu_result_d = alu_res;
            CAT_JMP:        alu_result_d = pc_plus4;
            CAT_LD, CAT_ST: alu_result_d = op_a + op_b;
            default:        alu_result_d = '0;
         endcase
         store_data_d = (catagory_i == CAT_ST) ? rs2_fwd : '0;
         rd_addr_d    = rd_addr_i;
         rd_write_d   = rd_write_i;
         rd_load_d    = rd_load_i;
         op_d         = op_i;
         cat_d        = catagory_i;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         alu_result_q <= '0;
         store_data_q <= '0;
         redirect_q   <= '0;
         rd_addr_q    <= '0;
         rd_write_q   <= 1'b0;
         rd_load_q    <= 1'b0;
         op_q         <= '0;
         cat_q        <= '0;
         err_q        <= 1'b0;
         err_held_q   <= 1'b0;
      end else begin
         alu_result_q <= alu_result_d;
         store_data_q <= store_data_d;
         redirect_q   <= redirect_d;
         rd_addr_q    <= rd_addr_d;
         rd_write_q   <= rd_write_d;
         rd_load_q    <= rd_load_d;
         op_q         <= op_d;
         cat_q        <= cat_d;
         err_q        <= err_d;
         err_held_q   <= err_held_d;
      end
   end

   assign alu_result_o   = alu_result_q;
   assign store_data_o   = store_data_q;
   assign rd_addr_o      = rd_addr_q;
   assign rd_write_o     = rd_write_q;
   assign rd_load_o      = rd_load_q;
   assign op_o           = op_q;
   assign catagory_o     = cat_q;
   assign branch_error_o = err_q;
   assign redirect_pc_o  = redirect_q;

endmodule
